// File: rtl/adder_seq_chunked.sv
// Multi-cycle ripple adder: adds CHUNK bits of a WIDTH-bit operand pair per clock,
// with valid/ready handshakes, carry-out and signed-overflow reporting.
module adder_seq_chunked #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic             carry_p0;
  logic [WIDTH-1:0] sum_p1;
  logic             carry_out_p1;
  logic             overflow_p1;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk;
  logic             accept;
  logic             last_chunk;

  // One chunk of the ripple: result carries at most CHUNK+1 bits.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Two's-complement overflow: like-signed operands produce a differently-signed sum.
  function automatic logic signed_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  assign in_ready   = (state == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx == LAST_IDX);
  assign out_valid  = (state == DONE);
  assign sum        = sum_p1;
  assign carry_out  = carry_out_p1;
  assign overflow   = overflow_p1;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        a_chunk = a_p0[k*CHUNK +: CHUNK];
        b_chunk = b_p0[k*CHUNK +: CHUNK];
      end
    end
    {c_chunk, s_chunk} = add_chunk(a_chunk, b_chunk, carry_p0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_chunk) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operand capture on the accept edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= a;
      b_p0 <= b;
    end
  end

  // Stage p1: chunk-serial accumulation into the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      carry_p0     <= 1'b0;
      sum_p1       <= '0;
      carry_out_p1 <= 1'b0;
      overflow_p1  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            carry_p0 <= carry_in;
            sum_p1   <= '0;
            idx      <= '0;
          end
        end
        BUSY: begin
          for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) sum_p1[k*CHUNK +: CHUNK] <= s_chunk;
          end
          carry_p0 <= c_chunk;
          if (last_chunk) begin
            carry_out_p1 <= c_chunk;
            overflow_p1  <= signed_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], s_chunk[CHUNK-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Directed bench for adder_seq_chunked at 8/2, 16/4 and 8/8 configurations.
module tb_adder_seq_chunked;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // WIDTH=8, CHUNK=2
  logic       iv8, ir8, ov8, ordy8, ci8, co8, of8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=16, CHUNK=4
  logic        iv16, ir16, ov16, ordy16, ci16, co16, of16;
  logic [15:0] a16, b16, sum16;
  // WIDTH=8, CHUNK=8
  logic       ivw, irw, ovw, ordyw, ciw, cow, ofw;
  logic [7:0] aw, bw, sumw;

  adder_seq_chunked #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .carry_in(ci8), .out_valid(ov8), .out_ready(ordy8), .sum(sum8),
    .carry_out(co8), .overflow(of8));

  adder_seq_chunked #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .carry_in(ci16), .out_valid(ov16), .out_ready(ordy16), .sum(sum16),
    .carry_out(co16), .overflow(of16));

  adder_seq_chunked #(.WIDTH(8), .CHUNK(8)) dutw (
    .clk(clk), .rst(rst), .in_valid(ivw), .in_ready(irw), .a(aw), .b(bw),
    .carry_in(ciw), .out_valid(ovw), .out_ready(ordyw), .sum(sumw),
    .carry_out(cow), .overflow(ofw));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept on the next rising edge, scramble operands afterwards, then check latency and result.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tci,
                     input logic [7:0] esum, input logic eco, input logic eov,
                     input string tag);
    a8 = ta; b8 = tb_; ci8 = tci; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = ~ta; b8 = ~tb_; ci8 = ~tci;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, {31'd0, ov8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, ov8}, 32'd1);
    chk({tag, "_sum"}, {24'd0, sum8}, {24'd0, esum});
    chk({tag, "_cout"}, {31'd0, co8}, {31'd0, eco});
    chk({tag, "_ovf"}, {31'd0, of8}, {31'd0, eov});
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'h55; ci8 = 1'b0; ordy8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; ordy16 = 1'b1;
    ivw = 1'b0; aw = '0; bw = '0; ciw = 1'b0; ordyw = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, ov8}, 32'd0);
    chk("rst_sum", {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, co8}, 32'd0);
    chk("rst_ovf", {31'd0, of8}, 32'd0);
    chk("rst_ready", {31'd0, ir8}, 32'd0);
    chk("rst_sum16", {16'd0, sum16}, 32'd0);
    rst = 1'b0; iv8 = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, ir8}, 32'd1);
    @(negedge clk);
    chk("post_rst_idle", {31'd0, ov8}, 32'd0);

    // All-ones + 1 wraps with carry out
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "t1");
    @(posedge clk);
    @(negedge clk);
    chk("t1_idle_ready", {31'd0, ir8}, 32'd1);
    chk("t1_idle_valid", {31'd0, ov8}, 32'd0);

    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "t2a");
    @(posedge clk);
    op8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "t2b");
    @(posedge clk);
    op8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, "ripple");
    @(posedge clk);
    op8(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, "negovf");
    @(posedge clk);

    // Backpressure: result held, in_valid ignored
    #1;
    ordy8 = 1'b0;
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "t3");
    for (int i = 0; i < 3; i++) begin
      iv8 = ~iv8; a8 = 8'hAA; b8 = 8'h11;
      @(negedge clk);
      chk("t3_hold_sum", {24'd0, sum8}, 32'h46);
      chk("t3_hold_ready", {31'd0, ir8}, 32'd0);
      chk("t3_hold_valid", {31'd0, ov8}, 32'd1);
    end
    iv8 = 1'b0; ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_release_ready", {31'd0, ir8}, 32'd1);
    chk("t3_release_valid", {31'd0, ov8}, 32'd0);
    chk("t3_release_sum", {24'd0, sum8}, 32'h46);

    // Operand stability (operands are scrambled after every accept)
    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "t4");
    @(posedge clk);

    // Reset mid-BUSY at idx==2
    #1;
    a8 = 8'hF0; b8 = 8'h0F; ci8 = 1'b1; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_abort_valid", {31'd0, ov8}, 32'd0);
    chk("t5_abort_sum", {24'd0, sum8}, 32'd0);
    chk("t5_abort_ready", {31'd0, ir8}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_pulse", {31'd0, ov8}, 32'd0);
    end
    op8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "t5");
    @(posedge clk);

    // WIDTH=16, CHUNK=4
    #1;
    a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("w16_early", {31'd0, ov16}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("w16_valid", {31'd0, ov16}, 32'd1);
    chk("w16_sum", {16'd0, sum16}, 32'd0);
    chk("w16_cout", {31'd0, co16}, 32'd1);
    chk("w16_ovf", {31'd0, of16}, 32'd0);

    // WIDTH=8, CHUNK=8: single BUSY cycle
    aw = 8'h80; bw = 8'h80; ciw = 1'b0; ivw = 1'b1;
    @(posedge clk); #1;
    ivw = 1'b0; aw = 8'h01; bw = 8'h01;
    @(negedge clk);
    chk("n1_early", {31'd0, ovw}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("n1_valid", {31'd0, ovw}, 32'd1);
    chk("n1_sum", {24'd0, sumw}, 32'd0);
    chk("n1_cout", {31'd0, cow}, 32'd1);
    chk("n1_ovf", {31'd0, ofw}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("n1_drain", {31'd0, ovw}, 32'd0);
    chk("n1_ready", {31'd0, irw}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
